scan_chain_rx: RTL and testbench

Receive-side model of the tag-chip scan interface. It samples the five scan lines (scan_id, scan_phi, scan_phi_bar, scan_data_in, scan_load_chip) from front-panel GPIO inputs. It deserializes each frame of NTX_BITS bits and presents the loaded word with a one-cycle valid strobe. The block sits behind gpio_ctrl on a second radio or in loopback, so the hop-code scan stream can be checked in hardware against the transmitted hop codes.

---
 rtl/scan_chain_rx_if.sv | 29 ++
 rtl/scan_chain_rx.sv | 138 +++++++++++++
 tb/tb_scan_chain_rx.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/scan_chain_rx_if.sv
// rtl/scan_chain_rx_if.sv - scan line inputs and deserialized frame outputs of scan_chain_rx
interface scan_chain_rx_if #(
    parameter int TX_BITS_WIDTH = 128,
    parameter int BIT_CNT_WIDTH = 7,
    parameter int NFRAME_WIDTH  = 16
);
    logic                     scan_id;
    logic                     scan_phi;
    logic                     scan_phi_bar;
    logic                     scan_data_in;
    logic                     scan_load_chip;
    logic [TX_BITS_WIDTH-1:0] data_out;
    logic                     data_valid;
    logic [BIT_CNT_WIDTH-1:0] nbits_cnt;
    logic [NFRAME_WIDTH-1:0]  nframes;
    logic                     frame_err;
    logic                     overlap_err;
    logic                     busy;

    modport master (
        output scan_id, scan_phi, scan_phi_bar, scan_data_in, scan_load_chip,
        input  data_out, data_valid, nbits_cnt, nframes, frame_err, overlap_err, busy
    );

    modport slave (
        input  scan_id, scan_phi, scan_phi_bar, scan_data_in, scan_load_chip,
        output data_out, data_valid, nbits_cnt, nframes, frame_err, overlap_err, busy
    );
endinterface

// File: rtl/scan_chain_rx.sv
// rtl/scan_chain_rx.sv - deserializes tag-chip scan frames sampled from asynchronous GPIO lines
module scan_chain_rx #(
    parameter int TX_BITS_WIDTH = 128,
    parameter int NTX_BITS      = 78,
    parameter int BIT_CNT_WIDTH = 7,
    parameter int NFRAME_WIDTH  = 16
) (
    input  logic           clk,
    input  logic           reset,
    scan_chain_rx_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CAPTURE, SHIFT} state_t;

    localparam logic [BIT_CNT_WIDTH-1:0] CNT_FULL = BIT_CNT_WIDTH'(NTX_BITS);
    localparam logic [BIT_CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [TX_BITS_WIDTH-1:0] FRAME_MASK =
        {TX_BITS_WIDTH{1'b1}} >> (TX_BITS_WIDTH - NTX_BITS);

    // control lines packed as {load, phi_bar, phi, id}
    logic [3:0] ctl_s0, ctl_s1, ctl_hist, rise_q;
    logic       data_s0, data_s1, data_q;
    logic       fall_id_q, overlap_q;

    state_t                   state, state_n;
    logic [TX_BITS_WIDTH-1:0] shift_reg, shift_n;
    logic                     bit_hold, hold_n;
    logic [BIT_CNT_WIDTH-1:0] nbits, nbits_n;
    logic [TX_BITS_WIDTH-1:0] dout, dout_n;
    logic [NFRAME_WIDTH-1:0]  nframes, nframes_n;
    logic                     valid_r, valid_n;
    logic                     ferr_r, ferr_n;
    logic                     ovl_r;

    // Edge events are registered so every event and the data bit carry the same latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctl_s0    <= '0;
            ctl_s1    <= '0;
            ctl_hist  <= '0;
            rise_q    <= '0;
            data_s0   <= 1'b0;
            data_s1   <= 1'b0;
            data_q    <= 1'b0;
            fall_id_q <= 1'b0;
            overlap_q <= 1'b0;
        end else begin
            ctl_s0    <= {bus.scan_load_chip, bus.scan_phi_bar, bus.scan_phi, bus.scan_id};
            ctl_s1    <= ctl_s0;
            ctl_hist  <= ctl_s1;
            rise_q    <= ctl_s1 & ~ctl_hist;
            data_s0   <= bus.scan_data_in;
            data_s1   <= data_s0;
            data_q    <= data_s1;
            fall_id_q <= ~ctl_s1[0] & ctl_hist[0];
            overlap_q <= ctl_s1[1] & ctl_s1[2];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_hold  <= 1'b0;
            nbits     <= '0;
            dout      <= '0;
            nframes   <= '0;
            valid_r   <= 1'b0;
            ferr_r    <= 1'b0;
            ovl_r     <= 1'b0;
        end else begin
            state     <= state_n;
            shift_reg <= shift_n;
            bit_hold  <= hold_n;
            nbits     <= nbits_n;
            dout      <= dout_n;
            nframes   <= nframes_n;
            valid_r   <= valid_n;
            ferr_r    <= ferr_n;
            ovl_r     <= overlap_q;
        end
    end

    always_comb begin
        state_n   = state;
        shift_n   = shift_reg;
        hold_n    = bit_hold;
        nbits_n   = nbits;
        dout_n    = dout;
        nframes_n = nframes;
        valid_n   = 1'b0;
        ferr_n    = 1'b0;
        case (state)
            IDLE: begin
                shift_n = '0;
                nbits_n = '0;
                if (rise_q[0]) state_n = CAPTURE;
            end
            CAPTURE, SHIFT: begin
                if (fall_id_q) begin
                    state_n = IDLE;
                    ferr_n  = (nbits != '0);
                    shift_n = '0;
                    nbits_n = '0;
                end else if (rise_q[3]) begin
                    // a phi_bar rise in the same cycle is deliberately dropped
                    if (nbits == CNT_FULL) begin
                        dout_n    = shift_reg & FRAME_MASK;
                        valid_n   = 1'b1;
                        nframes_n = nframes + NFRAME_WIDTH'(1);
                    end else begin
                        ferr_n = 1'b1;
                    end
                    state_n = CAPTURE;
                    shift_n = '0;
                    nbits_n = '0;
                end else if (!overlap_q) begin
                    if (rise_q[1]) begin
                        hold_n  = data_q;
                        state_n = SHIFT;
                    end else if (state == SHIFT && rise_q[2]) begin
                        shift_n = {shift_reg[TX_BITS_WIDTH-2:0], bit_hold};
                        if (nbits != CNT_MAX) nbits_n = nbits + BIT_CNT_WIDTH'(1);
                        state_n = CAPTURE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.data_out    = dout;
    assign bus.data_valid  = valid_r;
    assign bus.nbits_cnt   = nbits;
    assign bus.nframes     = nframes;
    assign bus.frame_err   = ferr_r;
    assign bus.overlap_err = ovl_r;
    assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_scan_chain_rx.sv
// tb/tb_scan_chain_rx.sv - self-checking bench for scan_chain_rx against a bit-queue frame model
module tb_scan_chain_rx;
    localparam int TXW = 128;
    localparam int NTX = 78;
    localparam int BCW = 7;
    localparam int NFW = 16;

    localparam logic [127:0] PAT = 128'h2AAA_5555_0F0F_F0F0_1234;
    localparam logic [127:0] PA  = 128'h3FFF_0000_FFFF_0000_8001;
    localparam logic [127:0] PB  = 128'h0123_4567_89AB_CDEF_0246;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    scan_chain_rx_if #(.TX_BITS_WIDTH(TXW), .BIT_CNT_WIDTH(BCW), .NFRAME_WIDTH(NFW)) sif ();

    scan_chain_rx #(
        .TX_BITS_WIDTH(TXW), .NTX_BITS(NTX), .BIT_CNT_WIDTH(BCW), .NFRAME_WIDTH(NFW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int load_cyc = 0;
    int last_valid_cyc = -1;
    int n_valid = 0;
    int n_ferr = 0;
    int n_ovl = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame model: pins seen 3 edges ago become events; bits collected in a queue.
    logic [4:0]   ph [0:4];  // {load, data, phi_bar, phi, id}
    logic         m_active = 1'b0;
    logic         m_wait = 1'b0;
    logic         m_hold = 1'b0;
    logic         m_q [$];
    logic [127:0] m_data = '0;
    logic [15:0]  m_nfr = '0;
    logic         m_valid = 1'b0;
    logic         m_ferr = 1'b0;
    logic         m_ovl = 1'b0;

    task model_step(input logic [4:0] n, input logic [4:0] o);
        logic [4:0]   r;
        logic         ovl;
        logic [127:0] w;
        r   = n & ~o;
        ovl = n[1] & n[2];
        m_valid = 1'b0;
        m_ferr  = 1'b0;
        m_ovl   = ovl;
        if (!m_active) begin
            m_q.delete();
            m_wait = 1'b0;
            if (r[0]) m_active = 1'b1;
        end else if (o[0] && !n[0]) begin
            m_ferr = (m_q.size() != 0);
            m_q.delete();
            m_active = 1'b0;
            m_wait = 1'b0;
        end else if (r[4]) begin
            if (m_q.size() == NTX) begin
                w = '0;
                foreach (m_q[i]) w = {w[126:0], m_q[i]};
                m_data = w;
                m_valid = 1'b1;
                m_nfr = m_nfr + 16'd1;
            end else begin
                m_ferr = 1'b1;
            end
            m_q.delete();
            m_wait = 1'b0;
        end else if (!ovl) begin
            if (r[1]) begin
                m_hold = n[3];
                m_wait = 1'b1;
            end else if (m_wait && r[2]) begin
                m_q.push_back(m_hold);
                m_wait = 1'b0;
            end
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 5; i++) ph[i] = '0;
            m_q.delete();
            m_active = 1'b0; m_wait = 1'b0; m_hold = 1'b0;
            m_data = '0; m_nfr = '0; m_valid = 1'b0; m_ferr = 1'b0; m_ovl = 1'b0;
        end else begin
            cyc++;
            for (int i = 4; i > 0; i--) ph[i] = ph[i-1];
            ph[0] = {sif.scan_load_chip, sif.scan_data_in, sif.scan_phi_bar, sif.scan_phi, sif.scan_id};
            model_step(ph[3], ph[4]);
        end
    end

    always @(negedge clk) begin
        if (cyc > 0 || reset) begin
            check("data_out",    sif.data_out, m_data);
            check("data_valid",  128'(sif.data_valid), 128'(m_valid));
            check("nbits_cnt",   128'(sif.nbits_cnt), 128'((m_q.size() > 127) ? 127 : m_q.size()));
            check("nframes",     128'(sif.nframes), 128'(m_nfr));
            check("frame_err",   128'(sif.frame_err), 128'(m_ferr));
            check("overlap_err", 128'(sif.overlap_err), 128'(m_ovl));
            check("busy",        128'(sif.busy), 128'(m_active));
        end
        if (sif.data_valid) begin n_valid++; last_valid_cyc = cyc; end
        if (sif.frame_err) n_ferr++;
        if (sif.overlap_err) n_ovl++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        sif.scan_data_in = b;
        sif.scan_phi = 1'b1;
        idle(10);
        sif.scan_phi = 1'b0;
        sif.scan_phi_bar = 1'b1;
        idle(10);
        sif.scan_phi_bar = 1'b0;
    endtask

    task automatic send_frame(input logic [127:0] w, input int nbits);
        for (int i = NTX - 1; i >= NTX - nbits; i--) send_bit(w[i]);
    endtask

    task automatic do_load();
        sif.scan_load_chip = 1'b1;
        load_cyc = cyc;
        idle(5);
        sif.scan_load_chip = 1'b0;
        idle(5);
    endtask

    task automatic clear_pins();
        sif.scan_id = 1'b0; sif.scan_phi = 1'b0; sif.scan_phi_bar = 1'b0;
        sif.scan_data_in = 1'b0; sif.scan_load_chip = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_pins();
        #1 reset = 1'b1;
        idle(3);
        check("rst_data_out", sif.data_out, 128'h0);
        check("rst_nframes", 128'(sif.nframes), 128'h0);
        check("rst_busy", 128'(sif.busy), 128'h0);
        check("rst_nbits", 128'(sif.nbits_cnt), 128'h0);
        reset = 1'b0;
        idle(5);

        // good frame
        n_valid = 0;
        sif.scan_id = 1'b1;
        idle(5);
        send_frame(PAT, 78);
        do_load();
        check("good_data", sif.data_out, PAT);
        check("good_nvalid", 128'(n_valid), 128'd1);
        check("good_latency", 128'(last_valid_cyc), 128'(load_cyc + 4));
        check("good_nframes", 128'(sif.nframes), 128'd1);

        // short frame
        n_ferr = 0;
        send_frame(PAT, 77);
        do_load();
        check("short_ferr", 128'(n_ferr), 128'd1);
        check("short_data", sif.data_out, PAT);
        check("short_nframes", 128'(sif.nframes), 128'd1);

        // overlap during bit 10
        send_frame(PA, 9);
        n_ovl = 0;
        sif.scan_data_in = 1'b1;
        sif.scan_phi = 1'b1;
        idle(3);
        sif.scan_phi_bar = 1'b1;
        idle(5);
        sif.scan_phi_bar = 1'b0;
        idle(2);
        sif.scan_phi = 1'b0;
        idle(10);
        check("ovl_pulses", 128'(n_ovl), 128'd5);
        check("ovl_nbits", 128'(sif.nbits_cnt), 128'd9);
        n_ferr = 0;
        sif.scan_id = 1'b0;
        idle(10);
        check("ovl_abort_ferr", 128'(n_ferr), 128'd1);

        // abort after 40 bits, then a good frame
        sif.scan_id = 1'b1;
        idle(5);
        send_frame(PB, 40);
        idle(5);
        check("abort_nbits40", 128'(sif.nbits_cnt), 128'd40);
        n_ferr = 0;
        sif.scan_id = 1'b0;
        idle(10);
        check("abort_ferr", 128'(n_ferr), 128'd1);
        check("abort_busy", 128'(sif.busy), 128'd0);
        check("abort_nbits", 128'(sif.nbits_cnt), 128'd0);
        check("abort_data", sif.data_out, PAT);
        sif.scan_id = 1'b1;
        idle(5);
        send_frame(PB, 78);
        do_load();
        check("after_abort_data", sif.data_out, PB);
        check("after_abort_nframes", 128'(sif.nframes), 128'd2);

        // back-to-back, scan_id held high
        n_valid = 0;
        send_frame(PA, 78);
        do_load();
        check("b2b_a", sif.data_out, PA);
        send_frame(PB, 78);
        do_load();
        check("b2b_b", sif.data_out, PB);
        check("b2b_nvalid", 128'(n_valid), 128'd2);
        check("b2b_nframes", 128'(sif.nframes), 128'd4);

        // asynchronous reset at bit 50
        send_frame(PA, 50);
        #2 reset = 1'b1;
        #1;
        check("arst_data", sif.data_out, 128'h0);
        check("arst_nframes", 128'(sif.nframes), 128'h0);
        check("arst_nbits", 128'(sif.nbits_cnt), 128'h0);
        check("arst_busy", 128'(sif.busy), 128'h0);
        check("arst_pulses", 128'({sif.data_valid, sif.frame_err, sif.overlap_err}), 128'h0);
        clear_pins();
        idle(3);
        reset = 1'b0;
        idle(5);
        sif.scan_id = 1'b1;
        idle(5);
        send_frame(PA, 78);
        do_load();
        check("post_rst_data", sif.data_out, PA);
        check("post_rst_nframes", 128'(sif.nframes), 128'd1);

        idle(10);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
